aes_add_round_key_seq: RTL
==========================

// Module: aes_add_round_key_seq
// PURPOSE
//  Parametrised AddRoundKey stage with its own round-key store and round sequencer.
//  Holds NUM_KEYS expanded round keys; each accepted En XORs Text with the next key.
//  Mode 0 (encrypt) walks keys 0..NUM_KEYS-1, Mode 1 (decrypt) walks NUM_KEYS-1..0.
//  Sits between the key-expansion block and the round datapath of encryptor/decryptor.
// PARAMETERS
//  DATA_W    128  state/key width in bits
//  NUM_KEYS  11   round keys stored (11/13/15 for AES-128/192/256)
//  KIDX_W    4    key index width, 2**KIDX_W >= NUM_KEYS
// PORTS
//  Clk         in   1        clock, all logic on rising edge
//  Rst         in   1        synchronous reset, active-high
//  KeyWrEn     in   1        write KeyWrData into store slot KeyWrIdx
//  KeyWrIdx    in   KIDX_W   key slot to write
//  KeyWrData   in   DATA_W   round key value
//  KeyErr      out  1        1-cycle pulse: key write rejected
//  Start       in   1        1-cycle pulse: begin a block sequence
//  Mode        in   1        sampled on Start; 0 = encrypt order, 1 = decrypt order
//  En          in   1        input valid; transfer when En & InRdy
//  Text        in   DATA_W   state to combine with current round key
//  InRdy       out  1        block accepts Text this cycle
//  Ry          out  1        ModifiedText valid; held until OutRdy
//  OutRdy      in   1        downstream accepts; transfer when Ry & OutRdy
//  ModifiedText out DATA_W   Text ^ Key[RoundIdx]
//  RoundIdx    out  KIDX_W   key index used for current ModifiedText
//  RoundLast   out  1        ModifiedText used the final key of the sequence
//  Busy        out  1        (state==ARMED) | Ry
// BEHAVIOUR
//  Reset (Rst=1 at edge, any state): state IDLE, RoundCnt 0, Ry 0, ModifiedText 0,
//   RoundIdx 0, RoundLast 0, KeyErr 0, all key slots 0. Mid-sequence reset discards data.
//  States: IDLE, ARMED.
//   IDLE: Start -> ARMED; ModeQ<=Mode; RoundCnt <= Mode ? NUM_KEYS-1 : 0.
//   ARMED: Start ignored; sequence ends when transfer uses terminal key -> IDLE.
//   Terminal key: NUM_KEYS-1 when ModeQ=0, 0 when ModeQ=1.
//  InRdy = (state==ARMED) & (~Ry | OutRdy). En with InRdy=0 is ignored (no effect).
//  Transfer (En & InRdy): next cycle ModifiedText=Text^Key[RoundCnt], RoundIdx=RoundCnt,
//   RoundLast=terminal, Ry=1. Latency 1 cycle. RoundCnt steps +1 (enc) / -1 (dec).
//  Ry & OutRdy without new transfer: Ry<=0; outputs otherwise held.
//  Ry & OutRdy with new transfer same cycle: new result loads, Ry stays 1 (1 result/cycle).
//  Ry & ~OutRdy: ModifiedText, RoundIdx, RoundLast stable; InRdy=0.
//  After terminal transfer state is IDLE; pending Ry still held until OutRdy; a new
//   Start is accepted in IDLE even while Ry pending (InRdy still gated by Ry).
//  Key writes: accepted only in IDLE with KeyWrIdx < NUM_KEYS; store updates at edge.
//   KeyWrEn in ARMED or KeyWrIdx >= NUM_KEYS: no write, KeyErr=1 next cycle.
//  KeyWrEn and Start same IDLE cycle: write commits, Start taken; first En sees new key.
//  RoundCnt never leaves 0..NUM_KEYS-1 (no wrap; terminal ends sequence).
//  Start and Rst together: Rst wins.
// TESTING
//  1 Reset: Rst=1 2 cycles -> Ry=0, InRdy=0, Busy=0, ModifiedText=0, KeyErr=0.
//  2 Single key: slot0=d0c9e1b6_14ee3f63_f9250c0c_a889c8a6, NUM_KEYS=1, Start Mode=0,
//    En Text=328831e0_435a3137_f6309807_a88da234, OutRdy=1 -> next cycle Ry=1,
//    ModifiedText=e241d056_57b40e54_0f15940b_00046a92, RoundLast=1, then IDLE.
//  3 Order: NUM_KEYS=3, slots k=1,2,3 (value k), Text=0 each; Mode=0 -> outputs 1,2,3
//    RoundIdx 0,1,2; Mode=1 -> 3,2,1 RoundIdx 2,1,0; RoundLast only on last.
//  4 Backpressure: hold OutRdy=0 3 cycles with Ry=1 -> InRdy=0, outputs stable, En
//    ignored; OutRdy=1 with En=1 -> back-to-back results, no round skipped.
//  5 Key errors: KeyWrEn while ARMED and KeyWrIdx=NUM_KEYS in IDLE -> KeyErr pulse,
//    store unchanged (rerun scenario 3, same results).
//  6 Mid-op reset: Rst after 2nd transfer of 3 -> IDLE, Ry=0, key slots 0; new Start
//    Mode=0 begins at RoundIdx 0.

Source files
------------

// File: rtl/aes_add_round_key_seq.sv
// AddRoundKey stage with a private round-key store and a round sequencer.
// Latency: 1 cycle from an accepted Text beat (En & InRdy) to ModifiedText/Ry.
// Backpressure: Ry holds its result until OutRdy; InRdy drops while a result is stalled.
//
// Ports:
//   Clk, Rst                 rising-edge clock, synchronous active-high reset
//   KeyWrEn/Idx/Data         round-key store write; KeyErr pulses when a write is rejected
//   Start, Mode              begin a block sequence; Mode 0 walks keys up, 1 walks keys down
//   En, Text, InRdy          input handshake (transfer on En & InRdy)
//   Ry, OutRdy               output handshake (transfer on Ry & OutRdy)
//   ModifiedText             Text ^ Key[RoundIdx]
//   RoundIdx, RoundLast      key index used, and whether it was the sequence's final key
//   Busy                     sequence armed or a result still pending
module aes_add_round_key_seq #(
  parameter int DATA_W   = 128,
  parameter int NUM_KEYS = 11,
  parameter int KIDX_W   = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              KeyWrEn,
  input  logic [KIDX_W-1:0] KeyWrIdx,
  input  logic [DATA_W-1:0] KeyWrData,
  output logic              KeyErr,
  input  logic              Start,
  input  logic              Mode,
  input  logic              En,
  input  logic [DATA_W-1:0] Text,
  output logic              InRdy,
  output logic              Ry,
  input  logic              OutRdy,
  output logic [DATA_W-1:0] ModifiedText,
  output logic [KIDX_W-1:0] RoundIdx,
  output logic              RoundLast,
  output logic              Busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  // Index of the highest stored key, and the key count widened by one bit so
  // an out-of-range write index compares correctly even when NUM_KEYS == 2**KIDX_W.
  localparam logic [KIDX_W-1:0] LAST_IDX   = KIDX_W'(NUM_KEYS - 1);
  localparam logic [KIDX_W:0]   NUM_KEYS_W = (KIDX_W + 1)'(NUM_KEYS);

  logic [0:0]        state;
  logic              mode_q;
  logic [KIDX_W-1:0] round_cnt;
  logic [DATA_W-1:0] key_mem [NUM_KEYS];

  logic              armed;
  logic              xfer;
  logic              terminal;
  logic              key_idx_ok;
  logic              key_wr_ok;
  logic [DATA_W-1:0] cur_key;

  assign armed = (state == ARMED);

  // A stalled result blocks new input; a result being drained this cycle does
  // not, which lets the stage sustain one result per cycle.
  assign InRdy = armed & (~Ry | OutRdy);
  assign xfer  = En & InRdy;
  assign Busy  = armed | Ry;

  // The terminal key is the last one in walk order: top slot going up,
  // slot 0 going down.
  assign terminal = mode_q ? (round_cnt == '0) : (round_cnt == LAST_IDX);

  // The store may only change between sequences so a block never sees a mix
  // of old and new round keys.
  assign key_idx_ok = ({1'b0, KeyWrIdx} < NUM_KEYS_W);
  assign key_wr_ok  = KeyWrEn & ~armed & key_idx_ok;

  // Key select as a compare-mux so the index width need not match the
  // store depth.
  always_comb begin
    cur_key = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (round_cnt == KIDX_W'(i)) begin
        cur_key = key_mem[i];
      end
    end
  end

  // Round-key store.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        key_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_wr_ok && (KeyWrIdx == KIDX_W'(i))) begin
          key_mem[i] <= KeyWrData;
        end
      end
    end
  end

  // Rejected writes report one cycle later, one pulse per rejected request.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      KeyErr <= 1'b0;
    end else begin
      KeyErr <= KeyWrEn & ~key_wr_ok;
    end
  end

  // Sequencer. The round counter only moves on a non-terminal transfer, so it
  // never leaves 0..NUM_KEYS-1; the terminal transfer returns to IDLE instead.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      round_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state     <= ARMED;
            mode_q    <= Mode;
            round_cnt <= Mode ? LAST_IDX : '0;
          end
        end
        ARMED: begin
          if (xfer) begin
            if (terminal) begin
              state <= IDLE;
            end else if (mode_q) begin
              round_cnt <= round_cnt - 1'b1;
            end else begin
              round_cnt <= round_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output register. A new transfer always overwrites (InRdy already
  // guarantees the previous result has been taken or is leaving this cycle).
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Ry           <= 1'b0;
      ModifiedText <= '0;
      RoundIdx     <= '0;
      RoundLast    <= 1'b0;
    end else if (xfer) begin
      Ry           <= 1'b1;
      ModifiedText <= Text ^ cur_key;
      RoundIdx     <= round_cnt;
      RoundLast    <= terminal;
    end else if (Ry && OutRdy) begin
      Ry <= 1'b0;
    end
  end

endmodule
